axis_fifo_wr_monitor: RTL and testbench

//  Write-side companion of the PON Tx FIFO read controller. Accepts the upstream AXI-Stream,

---
 rtl/axis_fifo_wr_monitor.sv | 135 +++++++++++++
 tb/tb_axis_fifo_wr_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_wr_monitor.sv
// Write side of the PON Tx FIFO: forwards AXI-Stream beats into the FIFO and tracks the
// FIFO level and the frames that hold enough data for the read controller to start.
module axis_fifo_wr_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int MIN_WORDS  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int LVL_W      = 10,
  parameter int ARM_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH:0]   fifo_wr_data,
  input  logic                  fifo_full,
  input  logic                  fifo_rd_en,
  input  logic                  fifo_rd_tlast,
  output logic                  fifo_min_data_write_done,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int               WC_W      = $clog2(MIN_WORDS + 1);
  localparam logic [WC_W-1:0]  MIN_WC    = WC_W'(MIN_WORDS);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [ARM_W-1:0] ARM_MAX   = '1;

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t           state;
  logic [WC_W-1:0]  wc;
  logic [LVL_W-1:0] level;
  logic [ARM_W-1:0] armed_cnt;
  logic [ARM_W-1:0] armed_nxt;
  logic             accept;
  logic             arm;
  logic             rd_frame;

  assign s_axis_tready = !rst && !fifo_full && (level < DEPTH_LVL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign fifo_wr_en    = accept;
  assign fifo_wr_data  = {s_axis_tlast, s_axis_tdata};
  assign fifo_level    = level;
  assign rd_frame      = fifo_rd_en && fifo_rd_tlast;

  // A frame is armed exactly once: on its MIN_WORDS-th beat, or on an earlier TLAST.
  always_comb begin
    arm = 1'b0;
    if (accept) begin
      case (state)
        IDLE:    arm = s_axis_tlast || (MIN_WORDS == 1);
        FILL:    arm = s_axis_tlast || ((wc + WC_W'(1)) == MIN_WC);
        default: arm = 1'b0;
      endcase
    end
  end

  always_comb begin
    armed_nxt = armed_cnt;
    if (arm && !rd_frame) begin
      if (armed_cnt != ARM_MAX) armed_nxt = armed_cnt + ARM_W'(1);
    end else if (!arm && rd_frame) begin
      if (armed_cnt != '0) armed_nxt = armed_cnt - ARM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wc    <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (s_axis_tlast) begin
            state <= IDLE;
            wc    <= '0;
          end else if (MIN_WORDS == 1) begin
            state <= ARMED;
            wc    <= MIN_WC;
          end else begin
            state <= FILL;
            wc    <= WC_W'(1);
          end
        end
        FILL: begin
          if (s_axis_tlast) begin
            state <= IDLE;
            wc    <= '0;
          end else if ((wc + WC_W'(1)) == MIN_WC) begin
            state <= ARMED;
            wc    <= MIN_WC;
          end else begin
            wc <= wc + WC_W'(1);
          end
        end
        ARMED: begin
          if (s_axis_tlast) begin
            state <= IDLE;
            wc    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          wc    <= '0;
        end
      endcase
    end
  end

  // A write seen while the level is at depth means fifo_full disagrees with our count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level                    <= '0;
      armed_cnt                <= '0;
      fifo_min_data_write_done <= 1'b0;
      overflow_err             <= 1'b0;
      underflow_err            <= 1'b0;
    end else begin
      armed_cnt                <= armed_nxt;
      fifo_min_data_write_done <= (armed_nxt != '0);
      if (s_axis_tvalid && !fifo_full && (level == DEPTH_LVL)) overflow_err <= 1'b1;
      if (fifo_rd_en && (level == '0)) underflow_err <= 1'b1;
      if (accept && !fifo_rd_en) begin
        level <= level + LVL_W'(1);
      end else if (!accept && fifo_rd_en && (level != '0)) begin
        level <= level - LVL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo_wr_monitor.sv
// Directed and randomized bench for axis_fifo_wr_monitor against a frame-level model.
module tb_axis_fifo_wr_monitor;

  localparam int DW      = 64;
  localparam int MINW    = 16;
  localparam int DEPTH   = 512;
  localparam int LVL_W   = 10;
  localparam int ARM_W   = 4;
  localparam int ARM_MAX = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;
  logic             wr_en;
  logic [DW:0]      wr_data;
  logic             full;
  logic             rd_en;
  logic             rd_tlast;
  logic             min_done;
  logic [LVL_W-1:0] level;
  logic             ovf;
  logic             unf;

  always #5 clk = ~clk;

  axis_fifo_wr_monitor #(
    .DATA_WIDTH(DW), .MIN_WORDS(MINW), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W), .ARM_W(ARM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axis_tdata(tdata),
    .s_axis_tvalid(tvalid),
    .s_axis_tlast(tlast),
    .s_axis_tready(tready),
    .fifo_wr_en(wr_en),
    .fifo_wr_data(wr_data),
    .fifo_full(full),
    .fifo_rd_en(rd_en),
    .fifo_rd_tlast(rd_tlast),
    .fifo_min_data_write_done(min_done),
    .fifo_level(level),
    .overflow_err(ovf),
    .underflow_err(unf)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: FIFO contents as a queue of tlast bits, beats in the open frame,
  // number of armed frames still in the FIFO, sticky error flags.
  int m_lvl, m_n, m_armed;
  bit m_ovf, m_unf;
  bit q[$];
  bit force_nofull;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit v, input bit l, input bit rd, input bit glitch = 1'b0);
    bit exp_rdy, acc, arm_ev, rd_frame;
    tvalid   = v;
    tlast    = l;
    tdata    = {$urandom, $urandom};
    rd_en    = rd;
    rd_tlast = (rd && q.size() > 0) ? q[0] : 1'b0;
    full     = force_nofull ? 1'b0 : ((m_lvl >= DEPTH) || glitch);
    #1;
    exp_rdy = !rst && !full && (m_lvl < DEPTH);
    acc     = v && exp_rdy;
    check("tready", tready, exp_rdy);
    check("wr_en", wr_en, acc);
    check("wr_data", wr_data, {l, tdata});
    @(posedge clk);
    if (rst) begin
      m_lvl = 0; m_n = 0; m_armed = 0; m_ovf = 0; m_unf = 0;
      q.delete();
    end else begin
      arm_ev = 0;
      if (acc) begin
        m_n++;
        arm_ev = (m_n == MINW) || (l && m_n < MINW);
        if (l) m_n = 0;
      end
      if (v && !full && m_lvl == DEPTH) m_ovf = 1;
      if (rd && m_lvl == 0) m_unf = 1;
      if (acc && !rd) m_lvl++;
      else if (rd && !acc && m_lvl > 0) m_lvl--;
      if (rd && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(l);
      rd_frame = rd && rd_tlast;
      if (arm_ev && !rd_frame) m_armed = (m_armed < ARM_MAX) ? m_armed + 1 : ARM_MAX;
      else if (!arm_ev && rd_frame && m_armed > 0) m_armed--;
    end
    #1;
    check("level", level, m_lvl);
    check("min_done", min_done, (m_armed != 0));
    check("overflow_err", ovf, m_ovf);
    check("underflow_err", unf, m_unf);
  endtask

  task automatic write_frame(input int len);
    for (int i = 1; i <= len; i++) step(1'b1, (i == len), 1'b0);
  endtask

  task automatic read_words(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; tvalid = 0; tlast = 0; tdata = '0; full = 0; rd_en = 0; rd_tlast = 0;
    force_nofull = 0;
    m_lvl = 0; m_n = 0; m_armed = 0; m_ovf = 0; m_unf = 0;
    @(posedge clk); #1;

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("rst_level", level, 0);
    check("rst_min_done", min_done, 1'b0);
    check("rst_tready", tready, 1'b0);
    rst = 1'b0;

    // 20-beat frame: armed on beat 16
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, (i == 20), 1'b0);
      if (i == 15) check("t1_done_beat15", min_done, 1'b0);
      if (i == 16) check("t1_done_beat16", min_done, 1'b1);
    end
    check("t1_level", level, 20);
    read_words(20);
    check("t1_drained_done", min_done, 1'b0);

    // Short frame armed by TLAST
    write_frame(3);
    check("t2_done_short", min_done, 1'b1);
    read_words(2);
    check("t2_done_before_last", min_done, 1'b1);
    read_words(1);
    check("t2_done_after_last", min_done, 1'b0);
    check("t2_level", level, 0);

    // Fill to depth; armed count saturates, then a write with a wrong full flag
    for (int f = 0; f < 16; f++) write_frame(32);
    check("t3_level_full", level, DEPTH);
    step(1'b1, 1'b0, 1'b0);
    check("t3_tready_at_depth", tready, 1'b0);
    check("t3_no_ovf_yet", ovf, 1'b0);
    force_nofull = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    force_nofull = 1'b0;
    check("t3_ovf", ovf, 1'b1);
    check("t3_level_stuck", level, DEPTH);
    read_words(DEPTH);
    check("t3_drained_done", min_done, 1'b0);
    check("t3_drained_level", level, 0);

    // Two back-to-back armed frames
    write_frame(16);
    write_frame(16);
    read_words(16);
    check("t4_one_left", min_done, 1'b1);
    read_words(16);
    check("t4_none_left", min_done, 1'b0);

    // Simultaneous write and read hold the level
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b1, ($urandom_range(0, 7) == 0), 1'b1);
    check("t5_level_held", level, 10);
    read_words(10);
    check("t5_no_unf_yet", unf, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("t5_unf", unf, 1'b1);
    check("t5_level_zero", level, 0);

    // Reset in the middle of a frame
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("t6_level", level, 0);
    check("t6_done", min_done, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, (i == 16), 1'b0);
      if (i == 15) check("t6_restart_beat15", min_done, 1'b0);
      if (i == 16) check("t6_restart_beat16", min_done, 1'b1);
    end
    read_words(16);

    // Randomized traffic with occasional full glitches
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
           (q.size() > 0) && ($urandom_range(0, 2) == 0), $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
